// File: rtl/menu_param_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// menu_param_ctrl_pkg
// Shared definitions for the parametrised menu controller:
//   - 2-bit menu state codes (HOME/PICK/EDIT/RUN) as plain localparams so the
//     encoding matches the state output seen by the VGA renderer
//   - bound_step(): one bounded +1/-1 step with saturate or wrap-around,
//     used for both the cursor and the channel values
// ---------------------------------------------------------------------------
package menu_param_ctrl_pkg;

  // Widest value the step helper handles; callers zero-extend into it.
  localparam int MAX_W  = 16;
  localparam int WIDE_W = MAX_W + 1;

  typedef logic [1:0] menu_state_t;

  localparam menu_state_t ST_HOME = 2'b00;
  localparam menu_state_t ST_PICK = 2'b01;
  localparam menu_state_t ST_EDIT = 2'b10;
  localparam menu_state_t ST_RUN  = 2'b11;

  // Increment (up=1) or decrement (up=0) val inside lo..hi.
  // The increment is formed one bit wider so that val=all-ones cannot
  // overflow before it is compared with the upper bound.
  function automatic logic [MAX_W-1:0] bound_step(
    input logic [MAX_W-1:0] val,
    input logic [MAX_W-1:0] lo,
    input logic [MAX_W-1:0] hi,
    input logic             up,
    input logic             wrap
  );
    logic [WIDE_W-1:0] wide;
    if (up) begin
      wide = {1'b0, val} + WIDE_W'(1);
      if (wide > {1'b0, hi}) begin
        wide = wrap ? {1'b0, lo} : {1'b0, hi};
      end
    end else begin
      if (val <= lo) begin
        wide = wrap ? {1'b0, hi} : {1'b0, lo};
      end else begin
        wide = {1'b0, val} - WIDE_W'(1);
      end
    end
    return wide[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/menu_param_ctrl_if.sv
// ---------------------------------------------------------------------------
// menu_param_ctrl_if
// Button and status bundle between the button conditioners / renderer and
// the menu controller.
//   left, right  : level, step down / up (hold to repeat)
//   en, back     : level, advance / cancel on rising edge
//   finish       : level, end of RUN
//   state        : 00 HOME, 01 PICK, 10 EDIT, 11 RUN
//   cursor       : selected channel
//   values       : packed channel values, ch0 in the LSBs
//   commit       : one-cycle pulse when an edit is accepted
// master = button side, slave = controller.
// ---------------------------------------------------------------------------
interface menu_param_ctrl_if
  import menu_param_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int VAL_W  = 4
);

  localparam int CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    left;
  logic                    right;
  logic                    en;
  logic                    back;
  logic                    finish;
  menu_state_t             state;
  logic [CUR_W-1:0]        cursor;
  logic [NUM_CH*VAL_W-1:0] values;
  logic                    commit;

  modport master (
    output left, right, en, back, finish,
    input  state, cursor, values, commit
  );

  modport slave (
    input  left, right, en, back, finish,
    output state, cursor, values, commit
  );

endinterface

// File: rtl/menu_param_ctrl_btn_repeat.sv
// ---------------------------------------------------------------------------
// btn_repeat
// Rising-edge detector with hold-to-repeat for one direction button.
//   clk_16  : tick clock
//   rst_n   : asynchronous active-low reset
//   btn_i   : button level
//   block_i : opposite button level; while high this button neither steps
//             nor keeps its repeat timing
//   step_o  : combinational step request for the current sample
// A step fires on the rising edge, again REP_DLY samples later, then every
// REP_RATE samples while the button stays held.
// ---------------------------------------------------------------------------
module btn_repeat #(
  parameter int REP_DLY  = 8,
  parameter int REP_RATE = 2
) (
  input  logic clk_16,
  input  logic rst_n,
  input  logic btn_i,
  input  logic block_i,
  output logic step_o
);

  localparam int CNT_MAX = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             prev_q;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt counts down to the next repeat step. active marks a hold that began
  // with a clean edge, so a button still held after a left&right clash stays
  // silent until it is released and pressed again.
  always_comb begin
    step_o   = 1'b0;
    active_d = 1'b0;
    cnt_d    = '0;
    if (btn_i && !block_i) begin
      if (!prev_q) begin
        step_o   = 1'b1;
        active_d = 1'b1;
        cnt_d    = CNT_W'(REP_DLY - 1);
      end else if (active_q) begin
        active_d = 1'b1;
        if (cnt_q == '0) begin
          step_o = 1'b1;
          cnt_d  = CNT_W'(REP_RATE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= btn_i;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/menu_param_ctrl.sv
// ---------------------------------------------------------------------------
// menu_param_ctrl
// Menu FSM holding NUM_CH bounded settings: HOME -> PICK -> EDIT -> RUN.
//   clk_16 : tick clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of menu_param_ctrl_if (buttons in, menu status out)
// PICK moves the cursor, EDIT adjusts values[cursor], back in EDIT restores
// the value captured on entry, en in EDIT pulses commit and enters RUN,
// finish in RUN returns HOME. Priority inside a state: en > back > steps.
// ---------------------------------------------------------------------------
module menu_param_ctrl
  import menu_param_ctrl_pkg::*;
#(
  parameter int                      NUM_CH   = 2,
  parameter int                      VAL_W    = 4,
  parameter logic [NUM_CH*VAL_W-1:0] MIN_VEC  = 8'hC0,
  parameter logic [NUM_CH*VAL_W-1:0] MAX_VEC  = 8'hF2,
  parameter logic [NUM_CH*VAL_W-1:0] INIT_VEC = 8'hF0,
  parameter int                      WRAP_EN  = 0,
  parameter int                      REP_DLY  = 8,
  parameter int                      REP_RATE = 2
) (
  input  logic              clk_16,
  input  logic              rst_n,
  menu_param_ctrl_if.slave  bus
);

  localparam int   CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic WRAP  = (WRAP_EN != 0);

  menu_state_t             state_q, state_d;
  logic [CUR_W-1:0]        cursor_q, cursor_d, cursor_new;
  logic [VAL_W-1:0]        val_q [NUM_CH];
  logic [VAL_W-1:0]        val_d [NUM_CH];
  logic [VAL_W-1:0]        shadow_q, shadow_d;
  logic                    commit_q, commit_d;
  logic                    en_prev_q, back_prev_q;
  logic                    en_p, back_p;
  logic                    l_step, r_step, step_any;
  logic [VAL_W-1:0]        cur_val, cur_min, cur_max, cur_new;
  logic                    wr_en;
  logic [VAL_W-1:0]        wr_val;
  logic [NUM_CH*VAL_W-1:0] values_pk;

  btn_repeat #(.REP_DLY(REP_DLY), .REP_RATE(REP_RATE)) u_rep_left (
    .clk_16  (clk_16),
    .rst_n   (rst_n),
    .btn_i   (bus.left),
    .block_i (bus.right),
    .step_o  (l_step)
  );

  btn_repeat #(.REP_DLY(REP_DLY), .REP_RATE(REP_RATE)) u_rep_right (
    .clk_16  (clk_16),
    .rst_n   (rst_n),
    .btn_i   (bus.right),
    .block_i (bus.left),
    .step_o  (r_step)
  );

  assign en_p     = bus.en   && !en_prev_q;
  assign back_p   = bus.back && !back_prev_q;
  assign step_any = l_step || r_step;

  // Pick out the channel under the cursor together with its bounds, then
  // precompute the stepped value and stepped cursor for the FSM.
  always_comb begin
    cur_val = '0;
    cur_min = '0;
    cur_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cursor_q == CUR_W'(i)) begin
        cur_val = val_q[i];
        cur_min = MIN_VEC[i*VAL_W +: VAL_W];
        cur_max = MAX_VEC[i*VAL_W +: VAL_W];
      end
    end
    cur_new    = VAL_W'(bound_step(MAX_W'(cur_val), MAX_W'(cur_min),
                                   MAX_W'(cur_max), r_step, WRAP));
    cursor_new = CUR_W'(bound_step(MAX_W'(cursor_q), '0,
                                   MAX_W'(NUM_CH - 1), r_step, WRAP));
  end

  // Menu FSM. A step arriving together with en_p/back_p is simply lost
  // because the edge branches are tested first.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    shadow_d = shadow_q;
    commit_d = 1'b0;
    wr_en    = 1'b0;
    wr_val   = cur_new;
    case (state_q)
      ST_HOME: begin
        if (en_p) state_d = ST_PICK;
      end
      ST_PICK: begin
        if (en_p) begin
          state_d  = ST_EDIT;
          shadow_d = cur_val;
        end else if (back_p) begin
          state_d = ST_HOME;
        end else if (step_any && (NUM_CH > 1)) begin
          cursor_d = cursor_new;
        end
      end
      ST_EDIT: begin
        if (en_p) begin
          state_d  = ST_RUN;
          commit_d = 1'b1;
        end else if (back_p) begin
          state_d = ST_PICK;
          wr_en   = 1'b1;
          wr_val  = shadow_q;
        end else if (step_any) begin
          wr_en = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.finish) state_d = ST_HOME;
      end
      default: state_d = ST_HOME;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      val_d[i] = val_q[i];
      if (wr_en && (cursor_q == CUR_W'(i))) val_d[i] = wr_val;
    end
  end

  // Reset mid-edit returns every channel to its initial value; the shadow
  // copy is discarded rather than restored.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOME;
      cursor_q    <= '0;
      shadow_q    <= '0;
      commit_q    <= 1'b0;
      en_prev_q   <= 1'b0;
      back_prev_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= INIT_VEC[i*VAL_W +: VAL_W];
      end
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      shadow_q    <= shadow_d;
      commit_q    <= commit_d;
      en_prev_q   <= bus.en;
      back_prev_q <= bus.back;
      for (int i = 0; i < NUM_CH; i++) begin
        val_q[i] <= val_d[i];
      end
    end
  end

  always_comb begin
    values_pk = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      values_pk[i*VAL_W +: VAL_W] = val_q[i];
    end
  end

  assign bus.state  = state_q;
  assign bus.cursor = cursor_q;
  assign bus.values = values_pk;
  assign bus.commit = commit_q;

endmodule

// File: tb/tb_menu_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_menu_param_ctrl
// Drives two controllers with identical button traffic: one saturating
// (WRAP_EN=0) and one wrapping (WRAP_EN=1). A behavioural model tracks both
// menus from the button rules and is compared after every clock.
// ---------------------------------------------------------------------------
module tb_menu_param_ctrl;

   localparam int NUM_CH   = 2;
   localparam int VAL_W    = 4;
   localparam int REP_DLY  = 8;
   localparam int REP_RATE = 2;
   localparam int MIN_V  [NUM_CH] = '{0, 12};
   localparam int MAX_V  [NUM_CH] = '{2, 15};
   localparam int INIT_V [NUM_CH] = '{0, 15};

   logic clk_16 = 1'b0;
   logic rst_n  = 1'b0;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = saturating DUT, 1 = wrapping DUT
   int mState  [2];
   int mCursor [2];
   int mVal    [2][NUM_CH];
   int mShadow [2];
   int mCommit [2];
   int leftHeld, rightHeld;
   bit prevLeft, prevRight, prevEn, prevBack;

   // free-running 16 "MHz" tick
   always #5 clk_16 = ~clk_16;

   menu_param_ctrl_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) busSat ();
   menu_param_ctrl_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) busWrap ();

   menu_param_ctrl #(
      .NUM_CH(NUM_CH), .VAL_W(VAL_W), .MIN_VEC(8'hC0), .MAX_VEC(8'hF2),
      .INIT_VEC(8'hF0), .WRAP_EN(0), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)
   ) dutSat (
      .clk_16 (clk_16),
      .rst_n  (rst_n),
      .bus    (busSat)
   );

   menu_param_ctrl #(
      .NUM_CH(NUM_CH), .VAL_W(VAL_W), .MIN_VEC(8'hC0), .MAX_VEC(8'hF2),
      .INIT_VEC(8'hF0), .WRAP_EN(1), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)
   ) dutWrap (
      .clk_16 (clk_16),
      .rst_n  (rst_n),
      .bus    (busWrap)
   );

   // single comparison point: counts and reports
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // a held button steps on its first sample and then REP_DLY, REP_DLY+REP_RATE, ... samples later
   function automatic bit stepFires(input int held);
      return (held == 0) || (held >= REP_DLY && ((held - REP_DLY) % REP_RATE) == 0);
   endfunction

   function automatic int stepValue(input int v, input int lo, input int hi, input bit up, input bit wrap);
      if (up) return (v + 1 > hi) ? (wrap ? lo : hi) : v + 1;
      return (v - 1 < lo) ? (wrap ? hi : lo) : v - 1;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mState[k]  = 0;
         mCursor[k] = 0;
         mShadow[k] = 0;
         mCommit[k] = 0;
         for (int c = 0; c < NUM_CH; c++) mVal[k][c] = INIT_V[c];
      end
      leftHeld  = -1;
      rightHeld = -1;
      prevLeft  = 1'b0;
      prevRight = 1'b0;
      prevEn    = 1'b0;
      prevBack  = 1'b0;
   endtask

   // advance the reference by one clock for the given sampled inputs
   task automatic modelClock(input bit l, input bit r, input bit e, input bit b, input bit f);
      bit lStep, rStep, enP, backP, wrap;
      int ch;
      if (l && !r) leftHeld = !prevLeft ? 0 : (leftHeld >= 0 ? leftHeld + 1 : -1);
      else         leftHeld = -1;
      if (r && !l) rightHeld = !prevRight ? 0 : (rightHeld >= 0 ? rightHeld + 1 : -1);
      else         rightHeld = -1;
      lStep = stepFires(leftHeld);
      rStep = stepFires(rightHeld);
      enP   = e && !prevEn;
      backP = b && !prevBack;
      for (int k = 0; k < 2; k++) begin
         wrap       = (k == 1);
         ch         = mCursor[k];
         mCommit[k] = 0;
         case (mState[k])
            0: if (enP) mState[k] = 1;
            1: begin
               if (enP) begin
                  mState[k]  = 2;
                  mShadow[k] = mVal[k][ch];
               end else if (backP) begin
                  mState[k] = 0;
               end else if (rStep || lStep) begin
                  mCursor[k] = stepValue(ch, 0, NUM_CH - 1, rStep, wrap);
               end
            end
            2: begin
               if (enP) begin
                  mState[k]  = 3;
                  mCommit[k] = 1;
               end else if (backP) begin
                  mState[k]   = 1;
                  mVal[k][ch] = mShadow[k];
               end else if (rStep || lStep) begin
                  mVal[k][ch] = stepValue(mVal[k][ch], MIN_V[ch], MAX_V[ch], rStep, wrap);
               end
            end
            default: if (f) mState[k] = 0;
         endcase
      end
      prevLeft  = l;
      prevRight = r;
      prevEn    = e;
      prevBack  = b;
   endtask

   task automatic compareAll(input string tag);
      int pk;
      for (int k = 0; k < 2; k++) begin
         pk = 0;
         for (int c = 0; c < NUM_CH; c++) pk += mVal[k][c] << (c * VAL_W);
         if (k == 0) begin
            checkOutput($sformatf("%s.sat.state", tag),  int'(busSat.state),  mState[k]);
            checkOutput($sformatf("%s.sat.cursor", tag), int'(busSat.cursor), mCursor[k]);
            checkOutput($sformatf("%s.sat.values", tag), int'(busSat.values), pk);
            checkOutput($sformatf("%s.sat.commit", tag), int'(busSat.commit), mCommit[k]);
         end else begin
            checkOutput($sformatf("%s.wrap.state", tag),  int'(busWrap.state),  mState[k]);
            checkOutput($sformatf("%s.wrap.cursor", tag), int'(busWrap.cursor), mCursor[k]);
            checkOutput($sformatf("%s.wrap.values", tag), int'(busWrap.values), pk);
            checkOutput($sformatf("%s.wrap.commit", tag), int'(busWrap.commit), mCommit[k]);
         end
      end
   endtask

   task automatic driveInputs(input bit l, input bit r, input bit e, input bit b, input bit f);
      busSat.left   = l;  busWrap.left   = l;
      busSat.right  = r;  busWrap.right  = r;
      busSat.en     = e;  busWrap.en     = e;
      busSat.back   = b;  busWrap.back   = b;
      busSat.finish = f;  busWrap.finish = f;
   endtask

   // one clock: drive on the falling edge, check just after the rising edge
   task automatic applyStimulus(input bit l, input bit r, input bit e, input bit b, input bit f,
                                input string tag);
      @(negedge clk_16);
      driveInputs(l, r, e, b, f);
      modelClock(l, r, e, b, f);
      @(posedge clk_16);
      #1;
      compareAll(tag);
   endtask

   // one cycle asserted followed by one idle cycle
   task automatic pulse(input bit l, input bit r, input bit e, input bit b, input bit f,
                        input string tag);
      applyStimulus(l, r, e, b, f, tag);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      bit l, r, e, b, f;
      driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      modelReset();
      #12;
      compareAll("reset");
      @(negedge clk_16);
      rst_n = 1'b1;

      // menu entry and saturating increments on ch0
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1.en");
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t1.en");
      for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t1.right");
      checkOutput("t1.stateEdit", int'(busSat.state), 2);
      checkOutput("t1.ch0Sat", int'(busSat.values[3:0]), 2);

      // cancel restores the value captured on entry
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.back");
      checkOutput("t3.statePick", int'(busSat.state), 1);
      checkOutput("t3.ch0Restored", int'(busSat.values[3:0]), 0);

      // hold-to-repeat on ch1
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t2.cursor");
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t2.en");
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2.hold");
         if (i == 1)  checkOutput("t2.step1",  int'(busSat.values[7:4]), 14);
         if (i == 8)  checkOutput("t2.noStep8", int'(busSat.values[7:4]), 14);
         if (i == 9)  checkOutput("t2.step9",  int'(busSat.values[7:4]), 13);
         if (i == 11) checkOutput("t2.step11", int'(busSat.values[7:4]), 12);
         if (i == 13) checkOutput("t2.step13", int'(busSat.values[7:4]), 12);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2.release");

      // commit and RUN
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4.en");
      checkOutput("t4.commitHigh", int'(busSat.commit), 1);
      checkOutput("t4.stateRun", int'(busSat.state), 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4.idle");
      checkOutput("t4.commitLow", int'(busSat.commit), 0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4.ignL");
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4.ignR");
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4.ignEn");
      checkOutput("t4.stillRun", int'(busSat.state), 3);
      checkOutput("t4.ch1Kept", int'(busSat.values[7:4]), 12);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4.finish");
      checkOutput("t4.home", int'(busSat.state), 0);
      pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4.finishHome");

      // wrap-around on ch0
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t5.pick");
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5.cursor0");
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t5.edit");
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5.r1");
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5.r2");
      checkOutput("t5.atMax", int'(busWrap.values[3:0]), 2);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5.wrapUp");
      checkOutput("t5.wrapToMin", int'(busWrap.values[3:0]), 0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5.wrapDn");
      checkOutput("t5.wrapToMax", int'(busWrap.values[3:0]), 2);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5.both");
      checkOutput("t5.bothNoChange", int'(busWrap.values[3:0]), 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5.release");
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5.back");

      // asynchronous reset in the middle of an edit
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t6.cursor1");
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t6.edit");
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t6.up");
      checkOutput("t6.ch1Before", int'(busSat.values[7:4]), 13);
      @(negedge clk_16);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("t6.asyncState", int'(busSat.state), 0);
      checkOutput("t6.asyncCh1", int'(busSat.values[7:4]), 15);
      compareAll("t6.async");
      @(posedge clk_16);
      @(negedge clk_16);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6.hold");
      checkOutput("t6.ch1Held", int'(busSat.values[7:4]), 15);

      // randomized traffic with sticky direction buttons so repeats occur
      l = 1'b0;
      r = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 10) l = ~l;
         if ($urandom_range(0, 99) < 10) r = ~r;
         e = ($urandom_range(0, 99) < 8);
         b = ($urandom_range(0, 99) < 5);
         f = ($urandom_range(0, 99) < 20);
         applyStimulus(l, r, e, b, f, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
